// File: rtl/fu_scoreboard_if.sv
// Decode, completion and status bundle between the pipeline controller
// and the long-latency unit scoreboard.
interface fu_scoreboard_if #(
    parameter int NUM_FU = 3,
    parameter int CNT_W  = 2
);
    logic [4:0]                     id_rs1_i;
    logic [4:0]                     id_rs2_i;
    logic [4:0]                     id_rs3_i;
    logic [2:0]                     id_use_rs_i;
    logic [2:0]                     id_rs_fp_i;
    logic [4:0]                     id_rd_i;
    logic                           id_rd_fp_i;
    logic                           id_writes_rd_i;
    logic                           id_long_i;
    logic [1:0]                     id_fu_i;
    logic                           issue_i;
    logic [1:0]                     cmp_valid_i;
    logic [1:0][4:0]                cmp_rd_i;
    logic [1:0]                     cmp_rd_fp_i;
    logic [1:0]                     cmp_writes_i;
    logic [1:0][1:0]                cmp_fu_i;
    logic                           stall_o;
    logic                           drained_o;
    logic [NUM_FU-1:0][CNT_W-1:0]   fu_cnt_o;
    logic                           err_o;

    modport master (
        output id_rs1_i, id_rs2_i, id_rs3_i, id_use_rs_i, id_rs_fp_i,
        output id_rd_i, id_rd_fp_i, id_writes_rd_i, id_long_i, id_fu_i,
        output issue_i, cmp_valid_i, cmp_rd_i, cmp_rd_fp_i,
        output cmp_writes_i, cmp_fu_i,
        input  stall_o, drained_o, fu_cnt_o, err_o
    );

    modport slave (
        input  id_rs1_i, id_rs2_i, id_rs3_i, id_use_rs_i, id_rs_fp_i,
        input  id_rd_i, id_rd_fp_i, id_writes_rd_i, id_long_i, id_fu_i,
        input  issue_i, cmp_valid_i, cmp_rd_i, cmp_rd_fp_i,
        input  cmp_writes_i, cmp_fu_i,
        output stall_o, drained_o, fu_cnt_o, err_o
    );
endinterface

// File: rtl/fu_scoreboard.sv
// Pending-write scoreboard and per-unit credit counters for MUL/FPU/VPU.
// Stalls decode on RAW, WAW and full units; flags drained and protocol errors.
module fu_scoreboard #(
    parameter int NUM_FU   = 3,
    parameter int FU_DEPTH = 2,
    parameter int CNT_W    = $clog2(FU_DEPTH + 1)
) (
    input logic           clk_i,
    input logic           rst_i,
    fu_scoreboard_if.slave sb
);
    // INT bit 0 is kept as a constant zero so x0 never reads as pending
    logic [31:0]                  pend_int;
    logic [31:0]                  pend_fp;
    logic [NUM_FU-1:0][CNT_W-1:0] cnt;
    logic                         err;
    logic                         drained;

    logic [31:0]                  nxt_int;
    logic [31:0]                  nxt_fp;
    logic [NUM_FU-1:0][CNT_W-1:0] nxt_cnt;
    logic                         nxt_err;
    logic                         nxt_drained;

    logic raw, waw, full, stall, accept, dup;
    logic [2:0][4:0] rs;

    function automatic logic hit(
        input logic [31:0] pi,
        input logic [31:0] pf,
        input logic        fp,
        input logic [4:0]  idx
    );
        return fp ? pf[idx] : pi[idx];
    endfunction

    assign rs = {sb.id_rs3_i, sb.id_rs2_i, sb.id_rs1_i};

    always_comb begin
        raw  = 1'b0;
        full = 1'b0;
        for (int i = 0; i < 3; i++) begin
            if (sb.id_use_rs_i[i] && hit(pend_int, pend_fp, sb.id_rs_fp_i[i], rs[i]))
                raw = 1'b1;
        end
        waw = sb.id_writes_rd_i &&
              hit(pend_int, pend_fp, sb.id_rd_fp_i, sb.id_rd_i);
        for (int f = 0; f < NUM_FU; f++) begin
            if (sb.id_long_i && sb.id_fu_i == 2'(f) &&
                cnt[f] == CNT_W'(FU_DEPTH))
                full = 1'b1;
        end
        stall  = raw | waw | full;
        accept = sb.issue_i & sb.id_long_i & ~stall;
    end

    assign dup = (sb.cmp_valid_i == 2'b11) && (sb.cmp_writes_i == 2'b11) &&
                 (sb.cmp_rd_i[0] == sb.cmp_rd_i[1]) &&
                 (sb.cmp_rd_fp_i[0] == sb.cmp_rd_fp_i[1]);

    always_comb begin
        logic [31:0] clr_int, clr_fp, set_int, set_fp;
        int          sum;
        clr_int = '0;
        clr_fp  = '0;
        set_int = '0;
        set_fp  = '0;
        sum     = 0;
        nxt_err = err | (sb.issue_i & stall);
        // Completions clear first; a duplicate on port 1 only flags the error
        for (int p = 0; p < 2; p++) begin
            if (sb.cmp_valid_i[p] && sb.cmp_writes_i[p]) begin
                if (p == 1 && dup)
                    nxt_err = 1'b1;
                else if (!hit(pend_int, pend_fp, sb.cmp_rd_fp_i[p], sb.cmp_rd_i[p]))
                    nxt_err = 1'b1;
                else if (sb.cmp_rd_fp_i[p])
                    clr_fp[sb.cmp_rd_i[p]] = 1'b1;
                else
                    clr_int[sb.cmp_rd_i[p]] = 1'b1;
            end
        end
        if (accept && sb.id_writes_rd_i) begin
            if (sb.id_rd_fp_i)
                set_fp[sb.id_rd_i] = 1'b1;
            else
                set_int[sb.id_rd_i] = 1'b1;
        end
        nxt_int = ((pend_int & ~clr_int) | set_int) & 32'hFFFF_FFFE;
        nxt_fp  = (pend_fp & ~clr_fp) | set_fp;
        for (int f = 0; f < NUM_FU; f++) begin
            sum = int'(cnt[f]);
            if (accept && sb.id_fu_i == 2'(f))
                sum = sum + 1;
            if (sb.cmp_valid_i[0] && sb.cmp_fu_i[0] == 2'(f))
                sum = sum - 1;
            if (sb.cmp_valid_i[1] && sb.cmp_fu_i[1] == 2'(f))
                sum = sum - 1;
            if (sum < 0) begin
                nxt_cnt[f] = '0;
                nxt_err    = 1'b1;
            end else if (sum > FU_DEPTH) begin
                nxt_cnt[f] = CNT_W'(FU_DEPTH);
                nxt_err    = 1'b1;
            end else begin
                nxt_cnt[f] = CNT_W'(sum);
            end
        end
        nxt_drained = (nxt_cnt == '0) && (nxt_int == '0) && (nxt_fp == '0);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pend_int <= '0;
            pend_fp  <= '0;
            cnt      <= '0;
            err      <= 1'b0;
            drained  <= 1'b1;
        end else begin
            pend_int <= nxt_int;
            pend_fp  <= nxt_fp;
            cnt      <= nxt_cnt;
            err      <= nxt_err;
            drained  <= nxt_drained;
        end
    end

    assign sb.stall_o   = stall;
    assign sb.drained_o = drained;
    assign sb.fu_cnt_o  = cnt;
    assign sb.err_o     = err;
endmodule
